// File: rtl/sample_hold_upsampler_pkg.sv
// Shared definitions for the sample-and-hold upsampler front end of the FIR + sigma-delta DAC chain.
package sample_hold_upsampler_pkg;

    // Must match the BW of the downstream moving-average filter and the DAC.
    localparam int DEFAULT_BW    = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_OSR_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sample_hold_upsampler_fifo.sv
// Small sample FIFO with a combinational head read so the hold FSM can register the head on the pop edge.
module sync_fifo_dp
    import sample_hold_upsampler_pkg::*;
#(
    parameter int BW    = DEFAULT_BW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic [BW-1:0]          push_data,
    input  logic                   pop,
    output logic [BW-1:0]          head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [BW-1:0] mem_reg [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer MSB separates full from empty when the index bits coincide.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
        end
    end

    // Storage is not reset: resetting the pointers already discards the contents.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sample_hold_upsampler.sv
// Buffers incoming audio samples and replays each one for osr_i cycles (zero-order hold),
// flagging a sticky underrun when the hold expires with nothing queued.
module sample_hold_upsampler
    import sample_hold_upsampler_pkg::*;
#(
    parameter int BW    = DEFAULT_BW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int OSR_W = DEFAULT_OSR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [OSR_W-1:0]       osr_i,
    input  logic [BW-1:0]          s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [BW-1:0]          smp_o,
    output logic                   strobe_o,
    output logic                   underrun_o,
    input  logic                   clr_i,
    output logic [$clog2(DEPTH):0] level_o
);

    state_t           state_reg;
    logic [OSR_W-1:0] cnt_reg;
    logic [BW-1:0]    smp_reg;
    logic             strobe_reg;
    logic             underrun_reg;

    logic [BW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OSR_W-1:0] cnt_reload;
    logic             hold_expired;
    logic             take;
    logic             underrun_set;

    sync_fifo_dp #(
        .BW    (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (s_valid_i),
        .push_data (s_data_i),
        .pop       (take),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_o)
    );

    // osr_i == 0 behaves as a one-cycle hold.
    assign cnt_reload   = (osr_i == '0) ? '0 : osr_i - OSR_W'(1);
    assign hold_expired = (state_reg == RUN) && (cnt_reg == '0);
    assign take         = ~fifo_empty && ((state_reg == IDLE) || hold_expired);
    assign underrun_set = hold_expired && fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            smp_reg      <= '0;
            strobe_reg   <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            strobe_reg <= take;
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        smp_reg   <= fifo_head;
                        cnt_reg   <= cnt_reload;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        smp_reg <= fifo_head;
                        cnt_reg <= cnt_reload;
                    end else if (underrun_set) begin
                        // Keep the last sample on the output rather than injecting zero.
                        cnt_reg <= cnt_reload;
                    end else begin
                        cnt_reg <= cnt_reg - OSR_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (underrun_set) begin
                underrun_reg <= 1'b1;
            end else if (clr_i) begin
                underrun_reg <= 1'b0;
            end
        end
    end

    assign s_ready_o  = ~fifo_full;
    assign smp_o      = smp_reg;
    assign strobe_o   = strobe_reg;
    assign underrun_o = underrun_reg;

endmodule

// File: tb/tb_sample_hold_upsampler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue/timestamp reference model.
module tb_sample_hold_upsampler;

    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int OSR_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk_i     = 1'b0;
    logic             rst_i     = 1'b1;
    logic [OSR_W-1:0] osr_i     = 8'd4;
    logic [BW-1:0]    s_data_i  = '0;
    logic             s_valid_i = 1'b0;
    logic             clr_i     = 1'b0;
    logic             s_ready_o;
    logic [BW-1:0]    smp_o;
    logic             strobe_o;
    logic             underrun_o;
    logic [LW-1:0]    level_o;

    sample_hold_upsampler #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .OSR_W (OSR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .osr_i      (osr_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .smp_o      (smp_o),
        .strobe_o   (strobe_o),
        .underrun_o (underrun_o),
        .clr_i      (clr_i),
        .level_o    (level_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued samples, absolute edge count and the edge at which the current hold ends.
    int          q[$];
    bit          started;
    longint      cyc = 0;
    longint      expiry_at;
    logic [15:0] m_smp;
    bit          m_strobe;
    bit          m_under;
    bit          last_push;
    longint      strobe_q[$];
    int          push_count;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int hold_of(input logic [OSR_W-1:0] o);
        return (o == 0) ? 1 : int'(o);
    endfunction

    task automatic model_reset();
        q.delete();
        started   = 0;
        m_smp     = '0;
        m_strobe  = 0;
        m_under   = 0;
        last_push = 0;
    endtask

    task automatic model_edge();
        int sz;
        bit expiry;
        bit pop;
        bit push;
        sz     = q.size();
        expiry = started && (cyc == expiry_at);
        pop    = (sz > 0) && (!started || expiry);
        push   = s_valid_i && (sz < DEPTH);
        m_strobe = pop;
        if (pop) begin
            m_smp     = 16'(q.pop_front());
            started   = 1;
            expiry_at = cyc + hold_of(osr_i);
        end else if (expiry) begin
            expiry_at = cyc + hold_of(osr_i);
        end
        if (expiry && !pop)  m_under = 1;
        else if (clr_i)      m_under = 0;
        if (push) q.push_back(int'(s_data_i));
        last_push = push;
        if (push) push_count++;
        cyc++;
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ":smp"},      32'(smp_o),      32'(m_smp));
        check_eq({ph, ":strobe"},   32'(strobe_o),   32'(m_strobe));
        check_eq({ph, ":underrun"}, 32'(underrun_o), 32'(m_under));
        check_eq({ph, ":level"},    32'(level_o),    32'(q.size()));
        check_eq({ph, ":ready"},    32'(s_ready_o),  32'(q.size() < DEPTH));
        if (strobe_o) strobe_q.push_back(cyc);
    endtask

    task automatic cycle(input string ph);
        @(posedge clk_i);
        if (!rst_i) model_edge();
        #1;
        compare_all(ph);
    endtask

    // Called just after a sampling point; asserts reset between edges and checks it takes effect at once.
    task automatic async_reset(input string ph);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        compare_all({ph, ":rst"});
        #1 rst_i = 1'b0;
    endtask

    task automatic push_word(input logic [BW-1:0] d, input string ph);
        bit done;
        done      = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        for (int i = 0; i < 600 && !done; i++) begin
            cycle(ph);
            done = last_push;
        end
        check_eq({ph, ":push_accepted"}, 32'(done), 32'd1);
        $display("[TB] %s push %h at cycle %0d", ph, d, cyc);
        s_valid_i = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all("init");
        rst_i = 1'b0;

        // Reset with three samples queued behind the one being held.
        osr_i = 8'd255;
        for (int i = 0; i < 4; i++) push_word(16'(16'h0100 + i), "t1");
        check_eq("t1:level_before", 32'(level_o), 32'd3);
        async_reset("t1");

        // Back-to-back samples with osr 4.
        osr_i = 8'd4;
        strobe_q.delete();
        push_word(16'h1234, "t2");
        push_word(16'h8000, "t2");
        repeat (10) cycle("t2");
        if (strobe_q.size() >= 2) check_eq("t2:gap", 32'(strobe_q[1] - strobe_q[0]), 32'd4);
        else check_eq("t2:strobes", 32'(strobe_q.size()), 32'd2);
        check_eq("t2:last", 32'(smp_o), 32'h8000);
        async_reset("t2");

        // osr 0 acts as osr 1, then underrun keeps the last sample.
        osr_i = 8'd0;
        push_word(16'h7FFF, "t3");
        repeat (2) cycle("t3");
        check_eq("t3:underrun", 32'(underrun_o), 32'd1);
        check_eq("t3:hold", 32'(smp_o), 32'h7FFF);
        async_reset("t3");

        // Source stalls against a long hold: FIFO fills, next push only after a pop.
        osr_i      = 8'd255;
        push_count = 0;
        s_valid_i  = 1'b1;
        s_data_i   = 16'($urandom);
        for (int i = 0; i < 270; i++) begin
            cycle("t4");
            if (last_push) s_data_i = 16'($urandom);
            if (i == 7) begin
                check_eq("t4:level_full", 32'(level_o), 32'(DEPTH));
                check_eq("t4:not_ready", 32'(s_ready_o), 32'd0);
            end
        end
        check_eq("t4:pushes", 32'(push_count), 32'd6);
        s_valid_i = 1'b0;
        async_reset("t4");

        // Clear colliding with a second empty expiry loses; clear alone wins.
        osr_i = 8'd2;
        push_word(16'hA5A5, "t5");
        for (int i = 0; i < 20 && !m_under; i++) cycle("t5");
        check_eq("t5:first_underrun", 32'(underrun_o), 32'd1);
        for (int i = 0; i < 20 && cyc != expiry_at; i++) cycle("t5");
        clr_i = 1'b1;
        cycle("t5");
        clr_i = 1'b0;
        check_eq("t5:set_wins", 32'(underrun_o), 32'd1);
        if (cyc == expiry_at) cycle("t5");
        clr_i = 1'b1;
        cycle("t5");
        clr_i = 1'b0;
        check_eq("t5:cleared", 32'(underrun_o), 32'd0);
        async_reset("t5");

        // osr changed during the first hold cycle of A only affects B.
        osr_i = 8'd4;
        strobe_q.delete();
        push_word(16'h0A0A, "t6");
        push_word(16'h0B0B, "t6");
        osr_i = 8'd2;
        push_word(16'h0C0C, "t6");
        repeat (10) cycle("t6");
        if (strobe_q.size() >= 3) begin
            check_eq("t6:gap_a", 32'(strobe_q[1] - strobe_q[0]), 32'd4);
            check_eq("t6:gap_b", 32'(strobe_q[2] - strobe_q[1]), 32'd2);
        end else begin
            check_eq("t6:strobes", 32'(strobe_q.size()), 32'd3);
        end
        async_reset("t6");

        // Randomized traffic; data held stable while a push is pending.
        osr_i = 8'd1;
        for (int i = 0; i < 4000; i++) begin
            if (!s_valid_i || last_push) begin
                s_valid_i = ($urandom_range(0, 99) < 60);
                s_data_i  = 16'($urandom);
            end
            if ($urandom_range(0, 199) == 0) osr_i = 8'($urandom_range(0, 6));
            clr_i = ($urandom_range(0, 49) == 0);
            cycle("rand");
            if ($urandom_range(0, 999) == 0) async_reset("rand");
        end
        clr_i     = 1'b0;
        s_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
